cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 8-bit lab CPU. It fetches instructions, holds the PC and the instruction register (IR), and sequences the 4x8 register file, the ALU and data memory.
- Instruction format: op[7:6], rs[5:4], rt[3:2], rd[1:0]; imm6 = IR[5:0] (jump only), addr offset = 0.
- Opcodes: 00 ADD rd=rs+rt; 01 LW rt=mem[rs]; 10 SW mem[rs]=rt; 11 J pc=pc+sext(imm6).
- Sits between instruction/data memory handshakes and the datapath control inputs (regdst, regwrite, alusrc, memread, memwrite, memtoreg).

Parameters:
CNT_W, 16, width of retired-instruction counter
PC_RESET, 8'h00, PC value loaded on reset

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
run  in  1  enables sequencing; sampled only in IDLE and at retire
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction memory ack; imem_rdata valid when high
imem_rdata  in  8  fetched instruction
dmem_ready  in  1  data memory ack for memread/memwrite
pc  out  8  program counter (fetch address)
instr  out  8  instruction register, fans out to regfile selects
regdst  out  1  1 = write rd, 0 = write rt
regwrite  out  1  register file write enable
alusrc  out  1  1 = ALU B operand is zero offset (address calc)
memread  out  1  data read strobe
memwrite  out  1  data write strobe
memtoreg  out  1  1 = writeback from memory
retired  out  1  one-cycle pulse per completed instruction
retired_count  out  CNT_W  completed instruction count, wraps
halted  out  1  halt status (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE, pc=PC_RESET, instr=0, retired_count=0. All strobes and retired are 0; halted=0.
- All control outputs are Moore, decoded from state and IR[7:6]. They are low in any state not listed below.
- IDLE: if run, go to FETCH; else hold.
- FETCH: imem_req=1, pc stable. Hold while imem_ready=0. On imem_ready=1: instr<=imem_rdata, pc<=pc+1 (mod 256), go to DECODE.
- DECODE: one cycle, register reads settle.
  - op 11: pc<=pc+sext(IR[5:0]) mod 256, using the already-incremented pc; retire.
  - Otherwise go to EXEC.
- EXEC: one cycle. alusrc=1 for op 01/10, else 0. op 00 goes to WB; op 01/10 go to MEM.
- MEM: memread=1 (op 01) or memwrite=1 (op 10), held until dmem_ready=1. Then op 01 goes to WB; op 10 retires.
- WB: regwrite=1 for exactly one cycle. regdst=(op==00); memtoreg=(op==01). Retire.
- Retire (on the transition edge): retired=1 for the next cycle, retired_count+=1 (wraps). Next state is FETCH if run=1, else IDLE.
- Latency with zero-wait memories (FETCH to retire pulse): J 2, ADD 4, SW 4, LW 5 cycles.
- run deasserted mid-instruction: the instruction completes, then the FSM parks in IDLE.
- imem_ready or dmem_ready high outside their wait states is ignored.
- pc wrap: 8'hFF+1 gives 8'h00. Jump arithmetic is 8-bit modulo.
- RESET mid-operation aborts immediately. No write strobe may remain high after RESET asserts.
- regwrite and memwrite are never high in the same cycle.

Optional Feature:
Macro: CPU_SEQ_HALT_EN.
- Defined: a J with imm6=6'h3F (self-loop) enters HALT instead of retiring normally. In HALT, halted=1, retired pulses once on entry, all strobes are 0, pc holds the jump's own address. Only RESET exits HALT.
- Undefined: no HALT state; halted is tied 0 and a self-jump loops forever.

Test Plan:
- Reset, then run=1, imem_rdata=8'b00_01_10_11 (ADD r3=r1+r2), imem_ready=1 always:
  - imem_req high 1 cycle, pc 0 to 1.
  - regwrite high exactly 1 cycle with regdst=1, memtoreg=0.
  - retired pulses 4 cycles after FETCH entry; retired_count=1.
- LW 8'h44 with dmem_ready delayed 3 cycles: memread held 4 cycles, then WB with regwrite=1, regdst=0, memtoreg=1. Total 8 cycles.
- SW 8'h98 with dmem_ready=1: memwrite high 1 cycle, regwrite never high, retired after 4 cycles.
- pc=8'h10, J imm6=6'h3E (-2): pc becomes 8'h0F. With CPU_SEQ_HALT_EN, J imm6=6'h3F from pc=8'h20 gives halted=1 and pc=8'h20 held.
- Assert RESET during MEM of SW with dmem_ready=0: memwrite drops asynchronously, state=IDLE, pc=0, retired_count unchanged at 0.
- imem_ready stalled 5 cycles then run dropped during EXEC: instr latches only on the ready cycle, the instruction completes, FSM returns to IDLE with imem_req=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM for the 8-bit lab CPU; optional HALT state via CPU_SEQ_HALT_EN
module cpu_sequencer #(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [7:0]       imem_rdata,
  input  logic             dmem_ready,
  output logic [7:0]       pc,
  output logic [7:0]       instr,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrc,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
`ifdef CPU_SEQ_HALT_EN
    S_HALT,
`endif
    S_WB
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  state_t      state;
  state_t      state_n;
  logic        retire;
  logic [1:0]  op;
  logic [5:0]  imm6;
  logic [7:0]  jump_pc;

  assign op      = instr[7:6];
  assign imm6    = instr[5:0];
  // pc already points past the jump, so the offset is relative to the next instruction
  assign jump_pc = pc + {{2{imm6[5]}}, imm6};

  // State register; async reset parks the FSM so every strobe drops at once
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic and retire detection
  always_comb begin
    state_n = state;
    retire  = 1'b0;
    case (state)
      S_IDLE:   if (run) state_n = S_FETCH;
      S_FETCH:  if (imem_ready) state_n = S_DECODE;
      S_DECODE: if (op == OP_J) retire = 1'b1;
                else state_n = S_EXEC;
      S_EXEC:   state_n = (op == OP_ADD) ? S_WB : S_MEM;
      S_MEM:    if (dmem_ready) begin
                  if (op == OP_LW) state_n = S_WB;
                  else retire = 1'b1;
                end
      S_WB:     retire = 1'b1;
`ifdef CPU_SEQ_HALT_EN
      S_HALT:   state_n = S_HALT;
`endif
      default:  state_n = S_IDLE;
    endcase
    if (retire) state_n = run ? S_FETCH : S_IDLE;
`ifdef CPU_SEQ_HALT_EN
    // A jump to itself still counts as retired, but the FSM stops there for good
    if (state == S_DECODE && op == OP_J && imm6 == 6'h3F) state_n = S_HALT;
`endif
  end

  // PC, IR and retire bookkeeping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc            <= PC_RESET;
      instr         <= 8'h00;
      retired       <= 1'b0;
      retired_count <= '0;
    end else begin
      retired <= retire;
      if (retire) retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state == S_FETCH && imem_ready) begin
        instr <= imem_rdata;
        pc    <= pc + 8'd1;
      end else if (state == S_DECODE && op == OP_J) begin
        pc <= jump_pc;
      end
    end
  end

  // Moore control outputs decoded from state and opcode
  always_comb begin
    imem_req = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  alusrc   = (op == OP_LW) || (op == OP_SW);
      S_MEM: begin
        memread  = (op == OP_LW);
        memwrite = (op == OP_SW);
      end
      S_WB: begin
        regwrite = 1'b1;
        regdst   = (op == OP_ADD);
        memtoreg = (op == OP_LW);
      end
`ifdef CPU_SEQ_HALT_EN
      S_HALT:  halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        run;
  logic        imem_req;
  logic        imem_ready;
  logic [7:0]  imem_rdata;
  logic        dmem_ready;
  logic [7:0]  pc;
  logic [7:0]  instr;
  logic        regdst, regwrite, alusrc, memread, memwrite, memtoreg;
  logic        retired;
  logic [15:0] retired_count;
  logic        halted;

  cpu_sequencer #(.CNT_W(16), .PC_RESET(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_ready(dmem_ready), .pc(pc), .instr(instr),
    .regdst(regdst), .regwrite(regwrite), .alusrc(alusrc),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .retired(retired), .retired_count(retired_count), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pcf; int word; int pca; int cnt; int lat;
    int nreq; int nrd; int nwr; int nrw; int nalu; int ndst; int nm2r;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ret = 0;
  int   mpc = 0;
  int   mcnt = 0;
  int   cur_wd = 0;

  // random-phase drivers vs directed drivers
  logic rand_en = 1'b0, mon_en = 1'b0, run_allow = 1'b0;
  logic d_run = 1'b0, d_iready = 1'b0, d_dready = 1'b0;
  logic [7:0] d_irdata = 8'h00;
  logic dir_run = 1'b0, dir_iready = 1'b0, dir_dready = 1'b0;
  logic [7:0] dir_irdata = 8'h00;

  assign run        = rand_en ? d_run    : dir_run;
  assign imem_ready = rand_en ? d_iready : dir_iready;
  assign imem_rdata = rand_en ? d_irdata : dir_irdata;
  assign dmem_ready = rand_en ? d_dready : dir_dready;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // instruction memory: picks each instruction, predicts its effects, serves it after wi stall cycles
  initial begin : imem_drv
    exp_t x;
    int op, lo, wi, wd, s;
    forever begin
      @(negedge CLK);
      if (!rand_en) d_iready = 1'b0;
      else if (!imem_req) begin
        d_iready = 1'($urandom_range(0, 1));
        d_irdata = 8'($urandom);
      end else begin
        op = $urandom_range(0, 3);
        lo = $urandom_range(0, 63);
`ifdef CPU_SEQ_HALT_EN
        if (op == 3 && lo == 63) lo = 62;
`endif
        wi = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        wd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        cur_wd = wd;
        x.pcf  = mpc;
        x.word = op * 64 + lo;
        s      = (lo >= 32) ? lo - 64 : lo;
        mpc    = (op == 3) ? ((mpc + 1 + s) & 255) : ((mpc + 1) & 255);
        mcnt   = (mcnt + 1) & 16'hFFFF;
        x.pca  = mpc;
        x.cnt  = mcnt;
        x.lat  = wi + ((op == 3) ? 2 : (op == 0) ? 4 : (op == 2) ? 4 + wd : 5 + wd);
        x.nreq = wi + 1;
        x.nrd  = (op == 1) ? wd + 1 : 0;
        x.nwr  = (op == 2) ? wd + 1 : 0;
        x.nrw  = (op == 0 || op == 1) ? 1 : 0;
        x.nalu = (op == 1 || op == 2) ? 1 : 0;
        x.ndst = (op == 0) ? 1 : 0;
        x.nm2r = (op == 1) ? 1 : 0;
        exp_q.push_back(x);
        for (int i = 0; i < wi; i++) begin
          d_iready = 1'b0;
          d_irdata = 8'($urandom);
          @(negedge CLK);
        end
        d_iready = 1'b1;
        d_irdata = 8'(x.word);
      end
    end
  end

  // data memory: acks after cur_wd stall cycles, noise otherwise
  initial begin : dmem_drv
    forever begin
      @(negedge CLK);
      if (!rand_en) d_dready = 1'b0;
      else if (!(memread || memwrite)) d_dready = 1'($urandom_range(0, 1));
      else begin
        for (int i = 0; i < cur_wd; i++) begin
          d_dready = 1'b0;
          @(negedge CLK);
        end
        d_dready = 1'b1;
      end
    end
  end

  // run toggles randomly so instructions sometimes finish into IDLE
  initial begin : run_drv
    forever begin
      @(negedge CLK);
      d_run = run_allow && ($urandom_range(0, 5) != 0);
    end
  end

  // monitor: accumulates per-instruction strobe activity and checks it at each retire pulse
  int cyc = 0, started = 0, c_req = 0, c_rd = 0, c_wr = 0, c_rw = 0, c_alu = 0, c_dst = 0, c_m2r = 0;
  exp_t e;
  always @(negedge CLK) begin
    #1;
    if (mon_en) begin
      if (regwrite && memwrite) chk("regwrite_memwrite_exclusive", 1, 0);
      if (retired) begin
        if (exp_q.size() == 0) chk("retire_without_instr", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("retire_pc", int'(pc), e.pca);
          chk("retire_instr", int'(instr), e.word);
          chk("retired_count", int'(retired_count), e.cnt);
          chk("latency", cyc, e.lat);
          chk("imem_req_cycles", c_req, e.nreq);
          chk("memread_cycles", c_rd, e.nrd);
          chk("memwrite_cycles", c_wr, e.nwr);
          chk("regwrite_cycles", c_rw, e.nrw);
          chk("alusrc_cycles", c_alu, e.nalu);
          chk("regdst_cycles", c_dst, e.ndst);
          chk("memtoreg_cycles", c_m2r, e.nm2r);
          chk("halted_low", int'(halted), 0);
          n_ret++;
        end
        cyc = 0; started = 0; c_req = 0; c_rd = 0; c_wr = 0;
        c_rw = 0; c_alu = 0; c_dst = 0; c_m2r = 0;
      end
      if (imem_req && imem_ready && exp_q.size() > 0) chk("fetch_pc", int'(pc), exp_q[0].pcf);
      if (imem_req) started = 1;
      if (started != 0) begin
        cyc++;
        c_req += int'(imem_req); c_rd += int'(memread); c_wr += int'(memwrite);
        c_rw += int'(regwrite); c_alu += int'(alusrc); c_dst += int'(regdst);
        c_m2r += int'(memtoreg);
      end
    end
  end

  initial begin : main
    int done;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    chk("rst_pc", int'(pc), 0);
    chk("rst_instr", int'(instr), 0);
    chk("rst_count", int'(retired_count), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_imem_req", int'(imem_req), 0);
    chk("rst_strobes", int'({regwrite, memwrite, memread, alusrc}), 0);
    chk("rst_halted", int'(halted), 0);

    @(negedge CLK);
    RESET = 1'b0; mon_en = 1'b1; run_allow = 1'b1; rand_en = 1'b1;
    for (int i = 0; i < 20000 && n_ret < 60; i++) @(negedge CLK);
    chk("random_phase_retired", int'(n_ret >= 60), 1);

    run_allow = 1'b0;
    done = 0;
    for (int i = 0; i < 500 && done == 0; i++) begin
      @(negedge CLK); #2;
      if (exp_q.size() == 0 && !imem_req) done = 1;
    end
    chk("drain_done", done, 1);
    repeat (4) @(negedge CLK);
    #2;
    chk("parked_no_fetch", int'(imem_req), 0);
    chk("parked_count", int'(retired_count), mcnt);
    mon_en = 1'b0;
    rand_en = 1'b0;

    // async reset while a store waits on the data memory
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; dir_run = 1'b1; dir_irdata = 8'h98; dir_iready = 1'b1; dir_dready = 1'b0;
    for (int i = 0; i < 20 && !memwrite; i++) @(negedge CLK);
    chk("sw_memwrite_seen", int'(memwrite), 1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_memwrite", int'(memwrite), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_count", int'(retired_count), 0);
    chk("abort_imem_req", int'(imem_req), 0);

`ifdef CPU_SEQ_HALT_EN
    // J +31 from 0 lands on 0x20, then a self-jump halts there
    @(negedge CLK);
    RESET = 1'b0; dir_irdata = 8'hDF;
    for (int i = 0; i < 20 && instr != 8'hDF; i++) @(negedge CLK);
    dir_irdata = 8'hFF;
    for (int i = 0; i < 20 && !halted; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    #2;
    chk("halt_flag", int'(halted), 1);
    chk("halt_pc", int'(pc), 8'h20);
    chk("halt_count", int'(retired_count), 2);
    chk("halt_no_fetch", int'(imem_req), 0);
    chk("halt_strobes", int'({regwrite, memwrite, memread}), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
